// File: rtl/canvas_pkg.sv
// Shared canvas definitions: sizes, FSM encoding, brush offsets and pixel indexing.
// DRAW_CANVAS_THICK_BRUSH_EN selects the 3x3 centred brush instead of the 2x2 brush.
package canvas_pkg;

  localparam int unsigned CANVAS_SIZE = 52;
  localparam int unsigned COORD_W     = 6;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDraw  = 2'd1,
    StClear = 2'd2
  } canvas_state_e;

`ifdef DRAW_CANVAS_THICK_BRUSH_EN
  localparam int BRUSH_LO = -1;
  localparam int BRUSH_HI = 1;
`else
  localparam int BRUSH_LO = 0;
  localparam int BRUSH_HI = 1;
`endif

  // Row-major bit index shared with the downsampler.
  function automatic int unsigned pixel_idx(input int unsigned x, input int unsigned y,
                                            input int unsigned size);
    return y * size + x;
  endfunction

endpackage

// File: rtl/canvas_line_stepper.sv
// Bresenham point generator: load a segment, then one point per step until last_o.
module canvas_line_stepper #(
  parameter int unsigned CoordW = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [CoordW-1:0] x0_i,
  input  logic [CoordW-1:0] y0_i,
  input  logic [CoordW-1:0] x1_i,
  input  logic [CoordW-1:0] y1_i,
  output logic [CoordW-1:0] x_o,
  output logic [CoordW-1:0] y_o,
  output logic              last_o
);

  localparam int unsigned ErrW = CoordW + 2;
  localparam int unsigned E2W  = ErrW + 1;

  logic [CoordW-1:0]        x_q, y_q, x1_q, y1_q;
  logic signed [CoordW:0]   adx_q, ndy_q;
  logic                     sx_neg_q, sy_neg_q;
  logic signed [ErrW-1:0]   err_q;

  logic signed [CoordW:0]   dx_w, dy_w, adx_w, ndy_w;
  logic signed [E2W-1:0]    e2_w;
  logic                     step_x_w, step_y_w;

  assign dx_w  = $signed({1'b0, x1_i}) - $signed({1'b0, x0_i});
  assign dy_w  = $signed({1'b0, y1_i}) - $signed({1'b0, y0_i});
  assign adx_w = dx_w[CoordW] ? -dx_w : dx_w;
  // dy is kept negated so both tests compare against the doubled error directly.
  assign ndy_w = dy_w[CoordW] ? dy_w : -dy_w;

  assign e2_w     = {err_q, 1'b0};
  assign step_x_w = e2_w >= E2W'(ndy_q);
  assign step_y_w = e2_w <= E2W'(adx_q);

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == x1_q) && (y_q == y1_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q      <= '0;
      y_q      <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      adx_q    <= '0;
      ndy_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      err_q    <= '0;
    end else if (load_i) begin
      x_q      <= x0_i;
      y_q      <= y0_i;
      x1_q     <= x1_i;
      y1_q     <= y1_i;
      adx_q    <= adx_w;
      ndy_q    <= ndy_w;
      sx_neg_q <= dx_w[CoordW];
      sy_neg_q <= dy_w[CoordW];
      err_q    <= ErrW'(adx_w) + ErrW'(ndy_w);
    end else if (step_i && !last_o) begin
      if (step_x_w) x_q <= sx_neg_q ? x_q - CoordW'(1) : x_q + CoordW'(1);
      if (step_y_w) y_q <= sy_neg_q ? y_q - CoordW'(1) : y_q + CoordW'(1);
      err_q <= err_q + (step_x_w ? ErrW'(ndy_q) : ErrW'(0))
                     + (step_y_w ? ErrW'(adx_q) : ErrW'(0));
    end
  end

endmodule

// File: rtl/draw_canvas.sv
// Pen-sample canvas writer: interpolates pen-down segments, stamps a brush, sequenced clear.
// DRAW_CANVAS_THICK_BRUSH_EN (via canvas_pkg) selects the 3x3 brush.
module draw_canvas
  import canvas_pkg::*;
#(
  parameter int unsigned Size   = CANVAS_SIZE,
  parameter int unsigned CoordW = COORD_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 pen_valid_i,
  output logic                 pen_ready_o,
  input  logic [CoordW-1:0]    pen_x_i,
  input  logic [CoordW-1:0]    pen_y_i,
  input  logic                 pen_down_i,
  input  logic                 clear_req_i,
  output logic                 clear_done_o,
  output logic                 busy_o,
  output logic [Size*Size-1:0] raw_canvas_o
);

  localparam int unsigned IdxW = $clog2(Size * Size);

  canvas_state_e       state_q, state_d;
  logic [Size*Size-1:0] canvas_q, canvas_d;
  logic [CoordW-1:0]   last_x_q, last_x_d, last_y_q, last_y_d;
  logic [CoordW-1:0]   row_q, row_d;
  logic                stroke_q, stroke_d;
  logic                pend_q, pend_d;
  logic                done_q, done_d;

  logic [CoordW-1:0]   smp_x, smp_y, cur_x, cur_y;
  logic                accept, seg_load, seg_last;

  function automatic logic [CoordW-1:0] clamp(input logic [CoordW-1:0] c);
    return (int'(c) >= int'(Size)) ? CoordW'(Size - 1) : c;
  endfunction

  function automatic logic on_canvas(input int c);
    return (c >= 0) && (c < int'(Size));
  endfunction

  assign smp_x        = clamp(pen_x_i);
  assign smp_y        = clamp(pen_y_i);
  assign pen_ready_o  = (state_q == StIdle) && !pend_q && !clear_req_i;
  assign accept       = pen_valid_i && pen_ready_o;
  assign seg_load     = accept && pen_down_i;
  assign busy_o       = (state_q != StIdle);
  assign clear_done_o = done_q;
  assign raw_canvas_o = canvas_q;

  canvas_line_stepper #(
    .CoordW (CoordW)
  ) u_stepper (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (seg_load),
    .step_i (state_q == StDraw),
    .x0_i   (stroke_q ? last_x_q : smp_x),
    .y0_i   (stroke_q ? last_y_q : smp_y),
    .x1_i   (smp_x),
    .y1_i   (smp_y),
    .x_o    (cur_x),
    .y_o    (cur_y),
    .last_o (seg_last)
  );

  always_comb begin
    state_d  = state_q;
    last_x_d = last_x_q;
    last_y_d = last_y_q;
    row_d    = row_q;
    stroke_d = stroke_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_req_i) begin
          state_d = StClear;
          row_d   = '0;
          pend_d  = 1'b0;
        end else if (accept) begin
          last_x_d = smp_x;
          last_y_d = smp_y;
          stroke_d = pen_down_i;
          if (pen_down_i) state_d = StDraw;
        end
      end
      StDraw: begin
        if (seg_last) begin
          if (pend_q || clear_req_i) begin
            state_d = StClear;
            row_d   = '0;
            pend_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else if (clear_req_i) begin
          pend_d = 1'b1;
        end
      end
      StClear: begin
        // Requests arriving mid-clear are absorbed by the clear already running.
        if (int'(row_q) == int'(Size) - 1) begin
          state_d  = StIdle;
          done_d   = 1'b1;
          stroke_d = 1'b0;
        end else begin
          row_d = row_q + CoordW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    canvas_d = canvas_q;
    if (state_q == StDraw) begin
      for (int oy = BRUSH_LO; oy <= BRUSH_HI; oy++) begin
        for (int ox = BRUSH_LO; ox <= BRUSH_HI; ox++) begin
          if (on_canvas(int'(cur_x) + ox) && on_canvas(int'(cur_y) + oy)) begin
            canvas_d[IdxW'(pixel_idx(unsigned'(int'(cur_x) + ox),
                                     unsigned'(int'(cur_y) + oy), Size))] = 1'b1;
          end
        end
      end
    end else if (state_q == StClear) begin
      canvas_d[IdxW'(pixel_idx(32'd0, 32'(row_q), Size)) +: Size] = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      canvas_q <= '0;
      last_x_q <= '0;
      last_y_q <= '0;
      row_q    <= '0;
      stroke_q <= 1'b0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      canvas_q <= canvas_d;
      last_x_q <= last_x_d;
      last_y_q <= last_y_d;
      row_q    <= row_d;
      stroke_q <= stroke_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_draw_canvas.sv
// Scoreboard bench for draw_canvas: expectations queued at issue, checked when pen_ready recovers.
module tb_draw_canvas;

  localparam int S = 52;
  localparam int N = S * S;

  logic         clk, rst_n;
  logic         pen_valid, pen_ready, pen_down, clear_req, clear_done, busy;
  logic [5:0]   pen_x, pen_y;
  logic [N-1:0] raw_canvas;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string        name;
    logic [N-1:0] cv;
    int           len;
    bit           chk_len;
    bit           done;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] model;

  draw_canvas dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pen_valid_i  (pen_valid),
    .pen_ready_o  (pen_ready),
    .pen_x_i      (pen_x),
    .pen_y_i      (pen_y),
    .pen_down_i   (pen_down),
    .clear_req_i  (clear_req),
    .clear_done_o (clear_done),
    .busy_o       (busy),
    .raw_canvas_o (raw_canvas)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_int(input string n, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask

  task automatic chk_cv(input string n, input logic [N-1:0] act, input logic [N-1:0] exp);
    int first;
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      first = -1;
      for (int i = 0; i < N; i++) if (first < 0 && act[i] !== exp[i]) first = i;
      $display("FAIL %s: canvas has %0d bits set, expected %0d; first differing bit %0d",
               n, $countones(act), $countones(exp), first);
    end
  endtask

  task automatic stamp(input int x, input int y);
`ifdef DRAW_CANVAS_THICK_BRUSH_EN
    for (int oy = -1; oy <= 1; oy++)
      for (int ox = -1; ox <= 1; ox++)
`else
    for (int oy = 0; oy <= 1; oy++)
      for (int ox = 0; ox <= 1; ox++)
`endif
        if (x + ox >= 0 && x + ox < S && y + oy >= 0 && y + oy < S)
          model[(y + oy) * S + x + ox] = 1'b1;
  endtask

  task automatic push(input string n, input int len, input bit chk_len, input bit done);
    exp_t e;
    e.name    = n;
    e.cv      = model;
    e.len     = len;
    e.chk_len = chk_len;
    e.done    = done;
    exp_q.push_back(e);
  endtask

  task automatic send(input int x, input int y, input bit down);
    @(posedge clk);
    #1;
    pen_valid = 1'b1;
    pen_x     = 6'(x);
    pen_y     = 6'(y);
    pen_down  = down;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pen_ready) break;
    end
    @(posedge clk);
    #1;
    pen_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(posedge clk);
    #1 clear_req = 1'b1;
    @(posedge clk);
    #1 clear_req = 1'b0;
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pen_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk_int("wait_ready_timeout", int'(ok), 1);
  endtask

  // Monitor: a transaction ends when pen_ready comes back after a low stretch.
  initial begin
    int   low;
    exp_t e;
    low = 0;
    forever begin
      @(negedge clk);
      if (!pen_ready) begin
        low++;
      end else if (low > 0) begin
        if (exp_q.size() == 0) begin
          chk_int("unexpected_completion", low, 0);
        end else begin
          e = exp_q.pop_front();
          chk_cv({e.name, "_canvas"}, raw_canvas, e.cv);
          if (e.chk_len) chk_int({e.name, "_ready_low"}, low, e.len);
          chk_int({e.name, "_clear_done"}, int'(clear_done), int'(e.done));
          chk_int({e.name, "_busy"}, int'(busy), 0);
        end
        low = 0;
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    pen_valid = 1'b0;
    pen_x     = '0;
    pen_y     = '0;
    pen_down  = 1'b0;
    clear_req = 1'b0;
    model     = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_cv("reset_canvas", raw_canvas, '0);
    chk_int("reset_ready", int'(pen_ready), 1);
    chk_int("reset_busy", int'(busy), 0);
    chk_int("reset_clear_done", int'(clear_done), 0);

    stamp(10, 20); push("pt_10_20", 1, 1'b1, 1'b0); send(10, 20, 1'b1); wait_ready();
    model = '0; push("clear_idle", 53, 1'b1, 1'b1); do_clear(); wait_ready();

    stamp(0, 0); push("pt_0_0", 1, 1'b1, 1'b0); send(0, 0, 1'b1); wait_ready();
    for (int x = 0; x <= 5; x++) stamp(x, 0);
    push("seg_0_5", 6, 1'b1, 1'b0); send(5, 0, 1'b1); wait_ready();

    send(0, 10, 1'b0); wait_ready();
    stamp(0, 10); push("pt_0_10", 1, 1'b1, 1'b0); send(0, 10, 1'b1); wait_ready();
    stamp(1, 11); stamp(2, 11); stamp(3, 12);
    push("diag", 4, 1'b1, 1'b0); send(3, 12, 1'b1); wait_ready();
    stamp(3, 13); stamp(3, 14); stamp(2, 15); stamp(2, 16); stamp(2, 17);
    push("steep", 6, 1'b1, 1'b0); send(2, 17, 1'b1); wait_ready();

    model = '0; push("clear_2", 53, 1'b1, 1'b1); do_clear(); wait_ready();
    stamp(51, 51); push("corner", 1, 1'b1, 1'b0); send(51, 51, 1'b1); wait_ready();
    send(60, 3, 1'b0); wait_ready();
    stamp(51, 3); push("clamp", 1, 1'b1, 1'b0); send(60, 3, 1'b1); wait_ready();

    model = '0; push("clear_3", 53, 1'b1, 1'b1); do_clear(); wait_ready();
    stamp(10, 20); push("pt_seg_start", 1, 1'b1, 1'b0); send(10, 20, 1'b1); wait_ready();
    // 21-point segment, clear requested mid-way: segment finishes, then 52 clear cycles.
    model = '0; push("seg_then_clear", 73, 1'b1, 1'b1);
    send(30, 20, 1'b1);
    repeat (3) @(posedge clk);
    #1 clear_req = 1'b1;
    @(posedge clk);
    #1 clear_req = 1'b0;
    wait_ready();
    stamp(5, 5); push("new_stroke", 1, 1'b1, 1'b0); send(5, 5, 1'b1); wait_ready();

    send(0, 30, 1'b0); wait_ready();
    stamp(0, 30); push("pt_0_30", 1, 1'b1, 1'b0); send(0, 30, 1'b1); wait_ready();
    model = '0; push("reset_mid_draw", 0, 1'b0, 1'b0);
    send(40, 30, 1'b1);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_cv("mid_reset_canvas", raw_canvas, '0);
    chk_int("mid_reset_ready", int'(pen_ready), 1);
    chk_int("mid_reset_busy", int'(busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    stamp(40, 40); push("after_reset", 1, 1'b1, 1'b0); send(40, 40, 1'b1); wait_ready();

    repeat (3) @(negedge clk);
    chk_int("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_canvas.md
# draw_canvas

Sequential writer that builds the 52×52 one-bit handwriting bitmap from a stream of pen samples. It is the producing end of the raw-canvas interface: its `raw_canvas` output feeds the 52→28 downsampler directly, using the same row-major bit order. It interpolates straight segments between consecutive pen-down samples, stamps a brush at each point, and supports a sequenced clear.

## Interface
- `SIZE`, 52: canvas width and height in pixels.
- `COORD_W`, 6: coordinate width; must satisfy 2^COORD_W ≥ SIZE.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous reset, active-low. Assertion is asynchronous; release is synchronous to `clk`.
- `pen_valid` input 1: pen sample present.
- `pen_ready` output 1: block accepts a sample this cycle.
- `pen_x` input COORD_W: column of the sample; 0 is the left edge.
- `pen_y` input COORD_W: row of the sample; 0 is the top edge.
- `pen_down` input 1: 1 means drawing, 0 means hovering.
- `clear_req` input 1: single-cycle request to erase the canvas.
- `clear_done` output 1: one-cycle pulse when a clear completes.
- `busy` output 1: high in DRAW or CLEAR.
- `raw_canvas` output SIZE*SIZE: registered bitmap; pixel (x,y) is bit y*SIZE+x.

## Operation
- States: IDLE, DRAW, CLEAR.
- **Handshake**
  - A transfer occurs when `pen_valid & pen_ready` at a rising edge.
  - `pen_ready` = (state==IDLE) & !clear_pending & !clear_req.
- **Clamping:** coordinates ≥ SIZE are clamped to SIZE-1 on acceptance.
- **Accepting a sample (IDLE)**
  - pen_down=0: the last point is updated and `stroke_active` is cleared. No pixels change and the state stays IDLE.
  - pen_down=1 with stroke_active=0: go to DRAW with a single-point segment (start = end = sample).
  - pen_down=1 with stroke_active=1: go to DRAW with segment last point → sample.
  - In both pen_down=1 cases, the last point is set to the sample and `stroke_active` is set.
- **DRAW**
  - Bresenham stepping: one point per cycle, the brush stamped at each point including both endpoints.
  - Length is max(|dx|,|dy|)+1 cycles. Return to IDLE after the endpoint cycle.
- **Brush:** 2×2 stamp, pixels (x..x+1, y..y+1). Pixels at ≥ SIZE are dropped (clipped, not wrapped).
- **Clear request**
  - `clear_req` in IDLE enters CLEAR and has priority over a simultaneous `pen_valid`, which is not accepted.
  - `clear_req` in DRAW or CLEAR sets `clear_pending`. The pending clear is serviced immediately after DRAW ends; during CLEAR it is absorbed.
- **CLEAR**
  - A row counter runs 0..SIZE-1 and zeroes one full row per cycle.
  - On the last row: pulse `clear_done`, reset `stroke_active`, return to IDLE.
  - Pen samples are never lost; they are simply not accepted while `pen_ready`=0.

## Timing
- **Reset values:** `raw_canvas`=0, state IDLE, `pen_ready`=1, `busy`=0, `clear_done`=0, `stroke_active`=0, `clear_pending`=0, last point (0,0).
- **Reset mid-operation:** immediate return to the reset values, with the canvas zeroed asynchronously.
- **Write latency:** a pixel stamped in DRAW cycle k is visible on `raw_canvas` after that edge.
- **Single-point sample:** `pen_ready` is low for exactly 1 cycle.
- **Segment:** `pen_ready` is low for max(|dx|,|dy|)+1 cycles.
- **Clear:** occupies exactly SIZE cycles. `clear_done` is high in the cycle after the last row is written, in IDLE with `pen_ready`=1 unless another clear is pending.
- **Step arithmetic:** signed error term of COORD_W+2 bits; dx and dy are computed as signed COORD_W+1 values.

## Configuration
- `DRAW_CANVAS_THICK_BRUSH_EN`
  - Defined: 3×3 brush centred on the point, (x-1..x+1, y-1..y+1). Negative and ≥ SIZE pixels are clipped.
  - Undefined: 2×2 brush as described in Operation.
- Timing and handshake are identical in both builds.

## Structure
- **Shared package `canvas_pkg`:**
  - Constants: CANVAS_SIZE=52, COORD_W=6.
  - State encoding: IDLE / DRAW / CLEAR.
  - Brush-offset constants.
  - The bit-index function y*SIZE+x, used by both the writer and the downsampler.
- **Sub-module `canvas_line_stepper`:** Bresenham point generator with start/load, current x/y, and a last-point flag. The top level owns the FSM, the bitmap register and stamping.

## Test plan
- Reset, then release → `raw_canvas`==0, `pen_ready`=1, `busy`=0.
- Pen-down (10,20) from pen-up → only bits 1050, 1051, 1102, 1103 set; `pen_ready` low for 1 cycle.
- Pen-down (0,0) then (5,0) → bits 0..6 and 52..58 set; `pen_ready` low 1 cycle, then 6 cycles.
- Pen-down (51,51) → only bit 2703 set. Pen-down (60,3) → clamped to x=51, bits 207 and 259 set.
- Draw (10,20), then `clear_req` during a 20-step segment → segment completes, then CLEAR runs 52 cycles, `clear_done` pulses once, canvas==0, and the next pen-down starts a new stroke.
- `rst_n` low mid-DRAW → canvas zero and `pen_ready`=1 immediately after release; no residual stamping.
